// File: rtl/ptr_sync_multi.sv
// Multi-flop Gray pointer synchronizer with binary conversion, change/delta reporting
// and illegal-transition (Hamming distance > 1) error tracking; all outputs registered.
module ptr_sync_multi #(
   parameter int Addr_Width  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 4
) (
   input  logic                  rd_clk,
   input  logic                  rd_rstn,
   input  logic [Addr_Width:0]   ptr_gray_in,
   input  logic                  err_clr,
   output logic [Addr_Width:0]   ptr_gray_sync,
   output logic [Addr_Width:0]   ptr_bin_sync,
   output logic                  ptr_changed,
   output logic [Addr_Width:0]   ptr_delta,
   output logic                  gray_err,
   output logic [ERR_W-1:0]      err_count
);

   localparam int PW = Addr_Width + 1;

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
         $error("ptr_sync_multi: SYNC_STAGES must be in 2..4");
      end
   endgenerate

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0]    sync_q [SYNC_STAGES];
   logic [PW-1:0]    g_prev_q;
   logic [PW-1:0]    bin_q, bin_d;
   logic [PW-1:0]    delta_q, delta_d;
   logic             changed_q, changed_d;
   logic             gray_err_q, gray_err_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [PW-1:0]    gray_diff;
   logic             illegal;

   // Plain flop chain: the first stage sees the raw foreign pointer, nothing in between.
   always_ff @(posedge rd_clk or negedge rd_rstn) begin
      if (!rd_rstn) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= ptr_gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign ptr_gray_sync = sync_q[SYNC_STAGES-1];

   // More than one set bit in the XOR means more than one Gray bit flipped.
   assign gray_diff = ptr_gray_sync ^ g_prev_q;
   assign illegal   = |(gray_diff & (gray_diff - PW'(1)));

   always_comb begin
      bin_d       = gray2bin(ptr_gray_sync);
      delta_d     = bin_d - gray2bin(g_prev_q);
      changed_d   = (gray_diff != '0);
      gray_err_d  = gray_err_q;
      err_count_d = err_count_q;
      if (illegal) begin
         gray_err_d = 1'b1;
         if (err_clr) begin
            err_count_d = ERR_W'(1);
         end else if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_W'(1);
         end
      end else if (err_clr) begin
         gray_err_d  = 1'b0;
         err_count_d = '0;
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rstn) begin
      if (!rd_rstn) begin
         g_prev_q    <= '0;
         bin_q       <= '0;
         delta_q     <= '0;
         changed_q   <= 1'b0;
         gray_err_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         g_prev_q    <= ptr_gray_sync;
         bin_q       <= bin_d;
         delta_q     <= delta_d;
         changed_q   <= changed_d;
         gray_err_q  <= gray_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign ptr_bin_sync = bin_q;
   assign ptr_delta    = delta_q;
   assign ptr_changed  = changed_q;
   assign gray_err     = gray_err_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_ptr_sync_multi.sv
// Directed bench for ptr_sync_multi (Addr_Width=3, SYNC_STAGES=2, ERR_W=2):
// a per-cycle vector table plus hand-written reset sequences.
module tb_ptr_sync_multi;

   logic       rd_clk;
   logic       rd_rstn;
   logic [3:0] ptr_gray_in;
   logic       err_clr;
   logic [3:0] ptr_gray_sync;
   logic [3:0] ptr_bin_sync;
   logic       ptr_changed;
   logic [3:0] ptr_delta;
   logic       gray_err;
   logic [1:0] err_count;

   int nvec = 0;
   int nerr = 0;

   ptr_sync_multi #(
      .Addr_Width (3),
      .SYNC_STAGES(2),
      .ERR_W      (2)
   ) dut (
      .rd_clk       (rd_clk),
      .rd_rstn      (rd_rstn),
      .ptr_gray_in  (ptr_gray_in),
      .err_clr      (err_clr),
      .ptr_gray_sync(ptr_gray_sync),
      .ptr_bin_sync (ptr_bin_sync),
      .ptr_changed  (ptr_changed),
      .ptr_delta    (ptr_delta),
      .gray_err     (gray_err),
      .err_count    (err_count)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   typedef struct {
      logic [3:0] gin;
      logic       clr;
      logic [3:0] gs;
      logic [3:0] bin;
      logic       chg;
      logic [3:0] dl;
      logic       err;
      logic [1:0] cnt;
   } vec_t;

   localparam int NV = 24;
   vec_t tbl [NV];

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic [3:0] gs, input logic [3:0] bin, input logic chg,
                            input logic [3:0] dl, input logic err, input logic [1:0] cnt);
      check("gray_sync", idx, {4'd0, ptr_gray_sync}, {4'd0, gs});
      check("bin_sync",  idx, {4'd0, ptr_bin_sync},  {4'd0, bin});
      check("changed",   idx, {7'd0, ptr_changed},   {7'd0, chg});
      check("delta",     idx, {4'd0, ptr_delta},     {4'd0, dl});
      check("gray_err",  idx, {7'd0, gray_err},      {7'd0, err});
      check("err_count", idx, {6'd0, err_count},     {6'd0, cnt});
   endtask

   function automatic vec_t mk(input logic [3:0] gin, input logic clr, input logic [3:0] gs,
                               input logic [3:0] bin, input logic chg, input logic [3:0] dl,
                               input logic err, input logic [1:0] cnt);
      vec_t v;
      v.gin = gin; v.clr = clr; v.gs = gs; v.bin = bin;
      v.chg = chg; v.dl = dl; v.err = err; v.cnt = cnt;
      return v;
   endfunction

   initial begin
      //            gin     clr   gs      bin     chg   dl      err   cnt
      tbl[0]  = mk(4'b0001, 1'b0, 4'h0, 4'd0,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[1]  = mk(4'b0001, 1'b0, 4'h1, 4'd0,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[2]  = mk(4'b0001, 1'b0, 4'h1, 4'd1,  1'b1, 4'd1,  1'b0, 2'd0);
      tbl[3]  = mk(4'b0000, 1'b0, 4'h1, 4'd1,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[4]  = mk(4'b1000, 1'b0, 4'h0, 4'd1,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[5]  = mk(4'b0000, 1'b0, 4'h8, 4'd0,  1'b1, 4'd15, 1'b0, 2'd0);
      tbl[6]  = mk(4'b0000, 1'b0, 4'h0, 4'd15, 1'b1, 4'd15, 1'b0, 2'd0);
      tbl[7]  = mk(4'b0011, 1'b0, 4'h0, 4'd0,  1'b1, 4'd1,  1'b0, 2'd0);
      tbl[8]  = mk(4'b0011, 1'b0, 4'h3, 4'd0,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[9]  = mk(4'b0011, 1'b0, 4'h3, 4'd2,  1'b1, 4'd2,  1'b1, 2'd1);
      tbl[10] = mk(4'b0000, 1'b0, 4'h3, 4'd2,  1'b0, 4'd0,  1'b1, 2'd1);
      tbl[11] = mk(4'b0011, 1'b0, 4'h0, 4'd2,  1'b0, 4'd0,  1'b1, 2'd1);
      tbl[12] = mk(4'b0000, 1'b0, 4'h3, 4'd0,  1'b1, 4'd14, 1'b1, 2'd2);
      tbl[13] = mk(4'b0011, 1'b0, 4'h0, 4'd2,  1'b1, 4'd2,  1'b1, 2'd3);
      tbl[14] = mk(4'b0011, 1'b0, 4'h3, 4'd0,  1'b1, 4'd14, 1'b1, 2'd3);
      tbl[15] = mk(4'b0011, 1'b0, 4'h3, 4'd2,  1'b1, 4'd2,  1'b1, 2'd3);
      tbl[16] = mk(4'b0011, 1'b1, 4'h3, 4'd2,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[17] = mk(4'b0000, 1'b0, 4'h3, 4'd2,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[18] = mk(4'b0011, 1'b0, 4'h0, 4'd2,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[19] = mk(4'b0000, 1'b0, 4'h3, 4'd0,  1'b1, 4'd14, 1'b1, 2'd1);
      tbl[20] = mk(4'b0000, 1'b0, 4'h0, 4'd2,  1'b1, 4'd2,  1'b1, 2'd2);
      tbl[21] = mk(4'b0000, 1'b1, 4'h0, 4'd0,  1'b1, 4'd14, 1'b1, 2'd1);
      tbl[22] = mk(4'b0000, 1'b1, 4'h0, 4'd0,  1'b0, 4'd0,  1'b0, 2'd0);
      tbl[23] = mk(4'b0000, 1'b0, 4'h0, 4'd0,  1'b0, 4'd0,  1'b0, 2'd0);

      // Reset held with a nonzero input: everything stays zero.
      rd_rstn     = 1'b0;
      ptr_gray_in = 4'b0110;
      err_clr     = 1'b0;
      repeat (3) @(posedge rd_clk);
      #1;
      check_all(100, 4'h0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
      #2 rd_rstn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         ptr_gray_in = tbl[i].gin;
         err_clr     = tbl[i].clr;
         @(posedge rd_clk);
         #1;
         check_all(i, tbl[i].gs, tbl[i].bin, tbl[i].chg, tbl[i].dl, tbl[i].err, tbl[i].cnt);
      end

      // Build up nonzero state with an illegal 0000->0011 jump.
      ptr_gray_in = 4'b0011;
      err_clr     = 1'b0;
      repeat (3) @(posedge rd_clk);
      #1;
      check_all(200, 4'h3, 4'd2, 1'b1, 4'd2, 1'b1, 2'd1);

      // Mid-stream reset clears outputs without any clock edge.
      #2 rd_rstn = 1'b0;
      #1;
      check_all(201, 4'h0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);

      @(posedge rd_clk);
      #1;
      check_all(202, 4'h0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
      ptr_gray_in = 4'b0001;
      #2 rd_rstn = 1'b1;

      // Post-release latency: sampled at first edge, visible after the second.
      @(posedge rd_clk);
      #1;
      check_all(203, 4'h0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
      @(posedge rd_clk);
      #1;
      check_all(204, 4'h1, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
      @(posedge rd_clk);
      #1;
      check_all(205, 4'h1, 4'd1, 1'b1, 4'd1, 1'b0, 2'd0);
      @(posedge rd_clk);
      #1;
      check_all(206, 4'h1, 4'd1, 1'b0, 4'd0, 1'b0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
